// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and register addresses for the PPU-side blocks.
//   dma_state_t      : sprite DMA sequencer states.
//   PPU_OAMDATA_ADDR : CPU address of the PPU OAMDATA register ($2004).
//   APU_OAMDMA_ADDR  : CPU address of the sprite DMA page register ($4014).
package ppu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

   localparam logic [15:0] PPU_OAMDATA_ADDR = 16'h2004;
   localparam logic [15:0] APU_OAMDMA_ADDR  = 16'h4014;

endpackage

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: sprite DMA initiator.
// It watches CPU writes for the DMA page register. On a hit it halts the CPU
// and copies CPU page {page, 00..FF} into OAMDATA, one read cycle and one
// write cycle per byte.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clkEn             : CPU-cycle strobe; nothing advances without it
//   cpuAddr_IN, cpuData_IN, cpuReadWrite_IN : snooped CPU bus (1 = read)
//   memData_IN        : read data returned during DMA read cycles
//   cpuHalt           : RDY hold to the CPU core
//   dmaActive         : bus mux select, DMA drives bus*_OUT
//   busAddr_OUT, busData_OUT, busReadWrite_OUT : DMA bus master outputs
//   oamData_EN        : OAMDATA select, high for the whole write cycle
//   dmaIndex          : current byte index
module oam_dma_controller
   import ppu_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = APU_OAMDMA_ADDR,
   parameter logic [15:0] OAM_DATA_ADDR = PPU_OAMDATA_ADDR,
   parameter logic        ALIGN_ODD     = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clkEn,
   input  logic [15:0] cpuAddr_IN,
   input  logic [7:0]  cpuData_IN,
   input  logic        cpuReadWrite_IN,
   input  logic [7:0]  memData_IN,
   output logic        cpuHalt,
   output logic        dmaActive,
   output logic [15:0] busAddr_OUT,
   output logic [7:0]  busData_OUT,
   output logic        busReadWrite_OUT,
   output logic        oamData_EN,
   output logic [7:0]  dmaIndex
);

   dma_state_t state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] index_q, index_d;
   logic [7:0] data_q, data_d;
   logic       parity_q, parity_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         page_q   <= 8'h00;
         index_q  <= 8'h00;
         data_q   <= 8'h00;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         index_q  <= index_d;
         data_q   <= data_d;
         parity_q <= parity_d;
      end
   end

   // Next state. The CPU-cycle parity runs even while idle so that the
   // alignment decision in HALT reflects the real CPU cycle.
   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      index_d  = index_q;
      data_d   = data_q;
      parity_d = parity_q;
      if (clkEn) begin
         parity_d = ~parity_q;
         unique case (state_q)
            IDLE: begin
               if (!cpuReadWrite_IN && cpuAddr_IN == DMA_REG_ADDR) begin
                  page_d  = cpuData_IN;
                  index_d = 8'h00;
                  state_d = HALT;
               end
            end
            HALT:  state_d = (ALIGN_ODD && parity_q) ? ALIGN : READ;
            ALIGN: state_d = READ;
            READ: begin
               data_d  = memData_IN;
               state_d = WRITE;
            end
            WRITE: begin
               index_d = index_q + 8'd1;
               state_d = (index_q == 8'hFF) ? IDLE : READ;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Moore output decode from registered state only.
   always_comb begin
      cpuHalt          = 1'b0;
      dmaActive        = 1'b0;
      busAddr_OUT      = 16'h0000;
      busData_OUT      = 8'h00;
      busReadWrite_OUT = 1'b1;
      oamData_EN       = 1'b0;
      unique case (state_q)
         IDLE: ;
         HALT, ALIGN: cpuHalt = 1'b1;
         READ: begin
            cpuHalt     = 1'b1;
            dmaActive   = 1'b1;
            busAddr_OUT = {page_q, index_q};
         end
         WRITE: begin
            cpuHalt          = 1'b1;
            dmaActive        = 1'b1;
            busAddr_OUT      = OAM_DATA_ADDR;
            busData_OUT      = data_q;
            busReadWrite_OUT = 1'b0;
            // Low again in the next READ, which gives the PPU one falling
            // edge per byte for its OAMADDR auto-increment.
            oamData_EN       = 1'b1;
         end
         default: ;
      endcase
   end

   assign dmaIndex = index_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: randomized CPU noise and data, checked
// cycle by cycle against a transfer-timeline model of the DMA.
module tb_oam_dma_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clkEn = 1'b0;
   logic [15:0] cpuAddr = 16'h0000;
   logic [7:0]  cpuData = 8'h00;
   logic        cpuRw = 1'b1;
   logic [7:0]  memData;
   logic        cpuHalt, dmaActive, busRw, oamEn;
   logic [15:0] busAddr;
   logic [7:0]  busData, dmaIndex;

   logic [7:0]  mem_key = 8'h00;

   oam_dma_controller dut (
      .clk(clk), .rst_n(rst_n), .clkEn(clkEn),
      .cpuAddr_IN(cpuAddr), .cpuData_IN(cpuData), .cpuReadWrite_IN(cpuRw),
      .memData_IN(memData),
      .cpuHalt(cpuHalt), .dmaActive(dmaActive), .busAddr_OUT(busAddr),
      .busData_OUT(busData), .busReadWrite_OUT(busRw), .oamData_EN(oamEn),
      .dmaIndex(dmaIndex)
   );

   always #5 clk = ~clk;

   // Memory model: byte at addr is addr[7:0] ^ key.
   assign memData = busAddr[7:0] ^ mem_key;

   wire [35:0] obs = {cpuHalt, dmaActive, busAddr, busData, busRw, oamEn, dmaIndex};
   localparam logic [35:0] IDLE_OUT = {1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h00};

   int checks = 0;
   int passed = 0;

   // Transfer model: t = clkEn cycles since entering the halt.
   bit         m_active = 0;
   int         m_t = 0;
   logic [7:0] m_page = 8'h00;
   bit         m_align = 0;
   int         m_n = 0;      // clkEn edges since reset

   int   halt_cnt = 0;
   int   falls = 0;
   logic prev_oam = 1'b0;

   function automatic logic [35:0] exp_out();
      int k;
      logic [7:0] b;
      if (!m_active) return IDLE_OUT;
      if (m_t < 1 + int'(m_align)) return {1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h00};
      k = m_t - 1 - int'(m_align);
      b = 8'(k / 2);
      if (k % 2 == 0) return {1'b1, 1'b1, m_page, b, 8'h00, 1'b1, 1'b0, b};
      return {1'b1, 1'b1, 16'h2004, b ^ mem_key, 1'b0, 1'b1, b};
   endfunction

   // Drive one clock with the given inputs, advance the model, observe at +1.
   task automatic step(input bit en, input bit rw, input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      clkEn = en; cpuRw = rw; cpuAddr = a; cpuData = d;
      @(posedge clk);
      if (en) begin
         if (!m_active) begin
            if (!rw && a == 16'h4014) begin
               m_active = 1; m_t = 0; m_page = d;
               m_align = ((m_n + 1) % 2) == 1;   // parity of the halt cycle
            end
         end else begin
            m_t++;
            if (m_t == 513 + int'(m_align)) m_active = 0;
         end
         m_n++;
      end
      #1;
      if (en && cpuHalt) halt_cnt++;
      if (prev_oam && !oamEn) falls++;
      prev_oam = oamEn;
   endtask

   // Random CPU noise while halted; reads only while idle so nothing
   // retriggers by accident.
   task automatic noise_step(input bit en);
      if (m_active) step(en, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      else          step(en, 1'b1, 16'($urandom), 8'($urandom));
   endtask

   task automatic do_reset();
      @(negedge clk);
      clkEn = 1'b0; cpuRw = 1'b1;
      rst_n = 1'b0;
      m_active = 0; m_n = 0; prev_oam = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle_then_trigger(input int idles, input logic [7:0] page);
      for (int i = 0; i < idles; i++) step(1'b1, 1'b1, 16'($urandom), 8'($urandom));
      halt_cnt = 0; falls = 0;
      step(1'b1, 1'b0, 16'h4014, page);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if (obs !== IDLE_OUT) $display("FAIL reset_state got %h want %h", obs, IDLE_OUT);
      else passed++;
      do_reset();
   endtask

   task automatic test_even();
      int guard = 0;
      do_reset();
      mem_key = 8'($urandom);
      idle_then_trigger(3, 8'h02);
      checks++;
      if (obs !== exp_out()) $display("FAIL even_first got %h want %h", obs, exp_out());
      else passed++;
      while (m_active && guard < 2000) begin
         noise_step(1'b1); guard++;
         checks++;
         if (obs !== exp_out()) $display("FAIL even_seq t=%0d got %h want %h", m_t, obs, exp_out());
         else passed++;
      end
      checks++;
      if (halt_cnt !== 513) $display("FAIL even_halt_len got %0d want 513", halt_cnt);
      else passed++;
      checks++;
      if (cpuHalt !== 1'b0 || dmaIndex !== 8'h00) $display("FAIL even_end halt=%b idx=%h want 0/00", cpuHalt, dmaIndex);
      else passed++;
   endtask

   task automatic test_odd();
      int guard = 0;
      int first_read = -1;
      do_reset();
      mem_key = 8'($urandom);
      idle_then_trigger(2, 8'($urandom));
      while (m_active && guard < 2000) begin
         noise_step(1'b1); guard++;
         if (dmaActive && first_read < 0) first_read = halt_cnt;
         checks++;
         if (obs !== exp_out()) $display("FAIL odd_seq t=%0d got %h want %h", m_t, obs, exp_out());
         else passed++;
      end
      checks++;
      if (first_read !== 3) $display("FAIL odd_first_read halt_cycle got %0d want 3", first_read);
      else passed++;
      checks++;
      if (halt_cnt !== 514) $display("FAIL odd_halt_len got %0d want 514", halt_cnt);
      else passed++;
   endtask

   task automatic test_datapath();
      int guard = 0;
      logic [7:0] oamaddr, start;
      do_reset();
      mem_key = 8'hFF;
      start = 8'($urandom);
      oamaddr = start;
      idle_then_trigger(3, 8'h07);
      while (m_active && guard < 2000) begin
         noise_step(1'b1); guard++;
         if (oamEn) begin
            checks++;
            if (busData !== ~dmaIndex || busAddr !== 16'h2004)
               $display("FAIL data_byte idx=%h got %h@%h want %h@2004", dmaIndex, busData, busAddr, ~dmaIndex);
            else passed++;
         end
         checks++;
         if (obs !== exp_out()) $display("FAIL data_seq t=%0d got %h want %h", m_t, obs, exp_out());
         else passed++;
      end
      oamaddr = 8'(int'(start) + falls);
      checks++;
      if (falls !== 256) $display("FAIL oam_falls got %0d want 256", falls);
      else passed++;
      checks++;
      if (oamaddr !== start) $display("FAIL oamaddr_wrap got %h want %h", oamaddr, start);
      else passed++;
   endtask

   task automatic test_gating();
      int guard = 0;
      int c = 0;
      int want;
      do_reset();
      mem_key = 8'($urandom);
      idle_then_trigger(3, 8'($urandom));
      want = 513 + int'(m_align);
      while (m_active && guard < 3000) begin
         noise_step(c % 3 == 2); c++; guard++;
         checks++;
         if (obs !== exp_out()) $display("FAIL gate_seq t=%0d got %h want %h", m_t, obs, exp_out());
         else passed++;
      end
      checks++;
      if (halt_cnt !== want) $display("FAIL gate_halt_len got %0d want %0d", halt_cnt, want);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      do_reset();
      mem_key = 8'($urandom);
      idle_then_trigger(3, 8'($urandom));
      while (!(exp_out() == {1'b1, 1'b1, 16'h2004, 8'h40 ^ mem_key, 1'b0, 1'b1, 8'h40}) && guard < 2000) begin
         noise_step(1'b1); guard++;
      end
      checks++;
      if (obs !== exp_out()) $display("FAIL mid_pre got %h want %h", obs, exp_out());
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== IDLE_OUT) $display("FAIL mid_async_reset got %h want %h", obs, IDLE_OUT);
      else passed++;
      m_active = 0; m_n = 0; prev_oam = 1'b0;
      @(negedge clk);
      clkEn = 1'b0;
      rst_n = 1'b1;
      idle_then_trigger(3, 8'($urandom));
      guard = 0;
      while (m_active && guard < 2000) begin
         noise_step(1'b1); guard++;
         checks++;
         if (obs !== exp_out()) $display("FAIL restart_seq t=%0d got %h want %h", m_t, obs, exp_out());
         else passed++;
      end
      checks++;
      if (halt_cnt !== 513) $display("FAIL restart_halt_len got %0d want 513", halt_cnt);
      else passed++;
   endtask

   task automatic test_ignored();
      int guard = 0;
      logic [7:0] pg;
      do_reset();
      step(1'b1, 1'b1, 16'h4014, 8'h33);
      checks++;
      if (obs !== IDLE_OUT) $display("FAIL read_4014 got %h want %h", obs, IDLE_OUT);
      else passed++;
      step(1'b1, 1'b0, 16'h4015, 8'h44);
      checks++;
      if (obs !== IDLE_OUT) $display("FAIL write_4015 got %h want %h", obs, IDLE_OUT);
      else passed++;
      mem_key = 8'($urandom);
      pg = 8'($urandom);
      idle_then_trigger(1, pg);
      while (m_active && guard < 2000) begin
         if (guard % 7 == 3) step(1'b1, 1'b0, 16'h4014, ~pg);
         else noise_step(1'b1);
         guard++;
         checks++;
         if (obs !== exp_out()) $display("FAIL retrigger_seq t=%0d got %h want %h", m_t, obs, exp_out());
         else passed++;
      end
      checks++;
      if (halt_cnt !== 513 + int'(m_align)) $display("FAIL retrigger_len got %0d want %0d", halt_cnt, 513 + int'(m_align));
      else passed++;
   endtask

   initial begin
      test_reset();
      test_even();
      test_odd();
      test_datapath();
      test_gating();
      test_reset_mid();
      test_ignored();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
